// File: rtl/shift_reg_rr_sched_if.sv
// Requester/response bundle for shift_reg_rr_sched: one request lane per requester
// and a single shared response lane tagged with the requester index.
interface shift_reg_rr_sched_if #(
  parameter int  NumReq = 4,
  parameter type dtype  = logic,
  parameter int  IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
);
  logic [NumReq-1:0] req_valid_i;
  logic [NumReq-1:0] req_ready_o;
  dtype              req_data_i [NumReq];
  logic [NumReq-1:0] rsp_valid_o;
  dtype              rsp_data_o;
  logic [IdxW-1:0]   rsp_idx_o;
  logic              busy_o;

  modport master (
    output req_valid_i, req_data_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_idx_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_data_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_idx_o, busy_o
  );
endinterface

// File: rtl/shift_reg_rr_sched.sv
// Round-robin scheduler feeding a fixed-latency valid-gated shift pipeline;
// items return Depth cycles after grant, tagged with their requester index.
module shift_reg_rr_sched #(
  parameter int  NumReq   = 4,
  parameter int  Depth    = 4,
  parameter int  MaxOutst = 2,
  parameter type dtype    = logic
) (
  input  logic                clk_i,
  input  logic                rst_i,
  shift_reg_rr_sched_if.slave bus
);
  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntW = $clog2(MaxOutst + 1);

  if (Depth < 1) begin : g_bad_depth
    $error("shift_reg_rr_sched: Depth must be at least 1");
  end

  logic [NumReq-1:0] eligible;
  logic [NumReq-1:0] gnt;
  logic [NumReq-1:0] rsp_vld;
  logic              gnt_any;
  logic [IdxW-1:0]   gnt_idx;

  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q [NumReq];
  logic [CntW-1:0]   cnt_d [NumReq];

  logic [Depth-1:0]  valid_q, valid_d;
  dtype              data_q [Depth];
  dtype              data_d [Depth];
  logic [IdxW-1:0]   idx_q  [Depth];
  logic [IdxW-1:0]   idx_d  [Depth];

  // Arbitration: registered counts only, so a same-cycle response frees nothing yet
  always_comb begin
    int cand;
    eligible = '0;
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand     = 0;
    for (int i = 0; i < NumReq; i++) begin
      eligible[i] = !rst_i && bus.req_valid_i[i] && (cnt_q[i] < CntW'(MaxOutst));
    end
    for (int off = 0; off < NumReq; off++) begin
      cand = int'(ptr_q) + off;
      if (cand >= NumReq) cand = cand - NumReq;
      if (!gnt_any && eligible[cand]) begin
        gnt_any   = 1'b1;
        gnt_idx   = IdxW'(cand);
        gnt[cand] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + IdxW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      rsp_vld[i] = valid_q[Depth-1] && (idx_q[Depth-1] == IdxW'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      cnt_d[i] = cnt_q[i];
      unique case ({gnt[i], rsp_vld[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CntW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CntW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // Pipeline: valid shifts every cycle, payload/index only move behind a valid
  always_comb begin
    valid_d[0] = gnt_any;
    data_d[0]  = gnt_any ? bus.req_data_i[gnt_idx] : data_q[0];
    idx_d[0]   = gnt_any ? gnt_idx : idx_q[0];
    for (int k = 1; k < Depth; k++) begin
      valid_d[k] = valid_q[k-1];
      data_d[k]  = valid_q[k-1] ? data_q[k-1] : data_q[k];
      idx_d[k]   = valid_q[k-1] ? idx_q[k-1]  : idx_q[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      valid_q <= '0;
      for (int i = 0; i < NumReq; i++) cnt_q[i] <= '0;
      for (int k = 0; k < Depth; k++) begin
        data_q[k] <= dtype'('0);
        idx_q[k]  <= '0;
      end
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      for (int i = 0; i < NumReq; i++) cnt_q[i] <= cnt_d[i];
      for (int k = 0; k < Depth; k++) begin
        data_q[k] <= data_d[k];
        idx_q[k]  <= idx_d[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NumReq; i++) begin
        assert (!(gnt[i] && !rsp_vld[i] && cnt_q[i] >= CntW'(MaxOutst)));
        assert (!(rsp_vld[i] && !gnt[i] && cnt_q[i] == '0));
      end
    end
  end

  assign bus.req_ready_o = gnt;
  assign bus.rsp_valid_o = rsp_vld;
  assign bus.rsp_data_o  = data_q[Depth-1];
  assign bus.rsp_idx_o   = idx_q[Depth-1];
  assign bus.busy_o      = |valid_q;

endmodule

// File: tb/tb_shift_reg_rr_sched.sv
// Directed bench for shift_reg_rr_sched (NumReq=4, Depth=4, MaxOutst=2, 8-bit payload).
module tb_shift_reg_rr_sched;
  localparam int NumReq   = 4;
  localparam int Depth    = 4;
  localparam int MaxOutst = 2;
  typedef logic [7:0] byte_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  shift_reg_rr_sched_if #(.NumReq(NumReq), .dtype(byte_t)) bus ();

  shift_reg_rr_sched #(
    .NumReq  (NumReq),
    .Depth   (Depth),
    .MaxOutst(MaxOutst),
    .dtype   (byte_t)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] oh(input int i);
    return 4'(1 << i);
  endfunction

  logic [7:0] cap_tbl;

  initial begin
    bus.req_valid_i = '0;
    for (int i = 0; i < NumReq; i++) bus.req_data_i[i] = '0;

    // Reset: ready gated off even with every requester valid
    rst = 1'b1;
    bus.req_valid_i = 4'hF;
    #1;
    chk_eq("rst_ready", 32'(bus.req_ready_o), 32'h0);
    tick();
    tick();
    chk_eq("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
    chk_eq("rst_rsp_data",  32'(bus.rsp_data_o),  32'h0);
    chk_eq("rst_rsp_idx",   32'(bus.rsp_idx_o),   32'h0);
    chk_eq("rst_busy",      32'(bus.busy_o),      32'h0);
    rst = 1'b0;
    bus.req_valid_i = '0;
    #1;

    // Single request from requester 2
    bus.req_data_i[2] = 8'h5A;
    bus.req_valid_i   = 4'b0100;
    #1;
    chk_eq("single_ready", 32'(bus.req_ready_o), 32'h4);
    tick();
    bus.req_valid_i = '0;
    for (int k = 1; k < Depth; k++) begin
      #1;
      chk_eq("single_busy",     32'(bus.busy_o),      32'h1);
      chk_eq("single_rsp_idle", 32'(bus.rsp_valid_o), 32'h0);
      tick();
    end
    chk_eq("single_rsp_valid", 32'(bus.rsp_valid_o), 32'h4);
    chk_eq("single_rsp_data",  32'(bus.rsp_data_o),  32'h5A);
    chk_eq("single_rsp_idx",   32'(bus.rsp_idx_o),   32'h2);
    chk_eq("single_busy_last", 32'(bus.busy_o),      32'h1);
    tick();
    chk_eq("single_rsp_done",  32'(bus.rsp_valid_o), 32'h0);
    chk_eq("single_busy_done", 32'(bus.busy_o),      32'h0);
    chk_eq("single_data_hold", 32'(bus.rsp_data_o),  32'h5A);

    // Wrap-around: pointer sits at 3
    bus.req_data_i[3] = 8'h33;
    bus.req_data_i[0] = 8'h30;
    bus.req_valid_i   = 4'b1001;
    #1;
    chk_eq("wrap_grant3", 32'(bus.req_ready_o), 32'h8);
    tick();
    chk_eq("wrap_grant0", 32'(bus.req_ready_o), 32'h1);
    tick();
    chk_eq("wrap_ptr1",   32'(bus.req_ready_o), 32'h8);
    bus.req_valid_i = '0;
    #1;
    tick();
    tick();
    chk_eq("wrap_rsp3_valid", 32'(bus.rsp_valid_o), 32'h8);
    chk_eq("wrap_rsp3_data",  32'(bus.rsp_data_o),  32'h33);
    chk_eq("wrap_rsp3_idx",   32'(bus.rsp_idx_o),   32'h3);
    tick();
    chk_eq("wrap_rsp0_valid", 32'(bus.rsp_valid_o), 32'h1);
    chk_eq("wrap_rsp0_data",  32'(bus.rsp_data_o),  32'h30);
    chk_eq("wrap_rsp0_idx",   32'(bus.rsp_idx_o),   32'h0);
    tick();
    chk_eq("wrap_rsp_done",   32'(bus.rsp_valid_o), 32'h0);

    // Fairness: all valid, pointer starts at 1, grants rotate 1,2,3,0,...
    for (int i = 0; i < NumReq; i++) bus.req_data_i[i] = 8'hA0 + 8'(i);
    for (int c = 0; c < 16; c++) begin
      bus.req_valid_i = (c < 12) ? 4'hF : 4'h0;
      #1;
      chk_eq("fair_ready", 32'(bus.req_ready_o), (c < 12) ? 32'(oh((1 + c) % 4)) : 32'h0);
      if (c >= 4) begin
        chk_eq("fair_rsp_valid", 32'(bus.rsp_valid_o), 32'(oh((c - 3) % 4)));
        chk_eq("fair_rsp_data",  32'(bus.rsp_data_o),  32'h0A0 + 32'((c - 3) % 4));
      end else begin
        chk_eq("fair_rsp_idle",  32'(bus.rsp_valid_o), 32'h0);
      end
      tick();
    end
    chk_eq("fair_busy_done", 32'(bus.busy_o), 32'h0);

    // Outstanding cap: only requester 1, two in flight at most
    cap_tbl = 8'h63;
    bus.req_data_i[1] = 8'h11;
    for (int c = 0; c < 12; c++) begin
      bus.req_valid_i = (c < 8) ? 4'b0010 : 4'b0000;
      #1;
      chk_eq("cap_ready", 32'(bus.req_ready_o), (c < 8 && cap_tbl[c]) ? 32'h2 : 32'h0);
      chk_eq("cap_rsp",   32'(bus.rsp_valid_o),
             (c == 4 || c == 5 || c == 9 || c == 10) ? 32'h2 : 32'h0);
      tick();
    end
    chk_eq("cap_busy_done", 32'(bus.busy_o), 32'h0);

    // Reset mid-flight: three items issued, then a one-cycle reset
    for (int i = 0; i < NumReq; i++) bus.req_data_i[i] = 8'hB0 + 8'(i);
    for (int r = 0; r < 3; r++) begin
      bus.req_valid_i = 4'hF;
      #1;
      chk_eq("mid_ready", 32'(bus.req_ready_o), (r == 0) ? 32'h4 : (r == 1) ? 32'h8 : 32'h1);
      tick();
    end
    rst = 1'b1;
    #1;
    chk_eq("mid_rst_ready", 32'(bus.req_ready_o), 32'h0);
    tick();
    rst = 1'b0;
    chk_eq("mid_busy_clr", 32'(bus.busy_o),      32'h0);
    chk_eq("mid_rsp_clr",  32'(bus.rsp_valid_o), 32'h0);
    bus.req_valid_i   = 4'b0011;
    bus.req_data_i[0] = 8'h70;
    #1;
    chk_eq("mid_post_grant", 32'(bus.req_ready_o), 32'h1);
    tick();
    chk_eq("mid_rsp_r5", 32'(bus.rsp_valid_o), 32'h0);
    bus.req_valid_i   = 4'b0001;
    bus.req_data_i[0] = 8'h71;
    #1;
    chk_eq("mid_cnt_clear", 32'(bus.req_ready_o), 32'h1);
    tick();
    chk_eq("mid_rsp_r6", 32'(bus.rsp_valid_o), 32'h0);
    #1;
    chk_eq("mid_cap_again", 32'(bus.req_ready_o), 32'h0);
    bus.req_valid_i = '0;
    tick();
    for (int r = 7; r < 12; r++) begin
      chk_eq("mid_rsp_valid", 32'(bus.rsp_valid_o), (r == 8 || r == 9) ? 32'h1 : 32'h0);
      if (r == 8) chk_eq("mid_rsp_data8", 32'(bus.rsp_data_o), 32'h70);
      if (r == 9) chk_eq("mid_rsp_data9", 32'(bus.rsp_data_o), 32'h71);
      tick();
    end

    // Idle: last response payload holds, nothing valid
    for (int c = 0; c < 10; c++) begin
      chk_eq("idle_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
      chk_eq("idle_rsp_data",  32'(bus.rsp_data_o),  32'h71);
      chk_eq("idle_rsp_idx",   32'(bus.rsp_idx_o),   32'h0);
      chk_eq("idle_busy",      32'(bus.busy_o),      32'h0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
